onehot_decoder_scan: RTL
========================

Name: onehot_decoder_scan

Overview:
Registered, parametrised N-to-one-hot decoder. It is the sequential successor to the combinational 3:8 decoder.
- Direct mode: decodes a validated select into a registered one-hot output.
- Scan mode: autonomously steps the one-hot output across all channels with a programmable dwell. Used for channel/enable strobing, e.g. LED/row scanning and mux sequencing.

Parameters:
SEL_W, 3, select width in bits.
N_OUT, 8, number of one-hot outputs; legal range 2 to 2**SEL_W.
DWELL_W, 8, width of the dwell count.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
en  input  1  block enable; 0 clears outputs and idles the block.
mode  input  1  0 = direct decode, 1 = auto-scan.
sel_valid  input  1  qualifies sel in direct mode.
sel  input  SEL_W  channel index to decode.
dwell  input  DWELL_W  scan step period minus 1, in clk cycles.
out  output  N_OUT  registered one-hot (or all-zero) channel select.
idx  output  SEL_W  binary index of the active bit in out.
out_valid  output  1  high when out holds exactly one set bit.
err  output  1  one-cycle pulse on an out-of-range sel.
wrap  output  1  one-cycle pulse when the scan wraps from N_OUT-1 to 0.

Behaviour:
- All outputs are registered. No combinational path from inputs to outputs.
- Reset (rst=1 at clk edge): out=0, idx=0, out_valid=0, err=0, wrap=0, dwell counter=0, state=IDLE. rst has priority over every other input, including mid-scan.
- States: IDLE, DIRECT, SCAN.
  - IDLE -> DIRECT on en=1 & mode=0.
  - IDLE -> SCAN on en=1 & mode=1.
  - DIRECT <-> SCAN on a mode change while en=1.
  - Any state -> IDLE on en=0.
- IDLE: out=0, out_valid=0, idx=0, counter=0. Inputs are ignored.
- Entry into DIRECT (from IDLE or SCAN): out=0, out_valid=0 until the first accepted sel.
- DIRECT, sel_valid=1 and sel<N_OUT: the next cycle gives out=1<<sel, idx=sel, out_valid=1. Latency is 1 cycle.
- DIRECT, sel_valid=1 and sel>=N_OUT: the next cycle gives out=0, out_valid=0, idx unchanged, and err=1 for exactly one cycle.
- DIRECT, sel_valid=0: out, idx and out_valid hold.
- Entry into SCAN (from IDLE or DIRECT): the next cycle gives out=1 (bit 0), idx=0, out_valid=1, counter=0.
- SCAN, each cycle:
  - If counter==dwell: counter->0, idx->idx+1, out shifts left by one.
  - Otherwise counter->counter+1.
  - Each channel is therefore active for exactly dwell+1 cycles. dwell=0 advances every cycle.
- SCAN wrap: when advancing from idx=N_OUT-1, idx->0 and out->bit 0, with wrap=1 in the same cycle the new out appears. The index wraps at N_OUT, not 2**SEL_W.
- dwell is sampled every cycle. A change mid-step takes effect against the running counter. If the new dwell is below counter, the counter runs to the DWELL_W rollover and then matches. This is legal and must not lock up.
- SCAN ignores sel_valid and sel, and never asserts err.
- Simultaneous events:
  - rst beats en=0, which beats a mode change, which beats sel_valid.
  - A mode change in the same cycle as sel_valid discards the sel.
- Invariant: out is either 0 or exactly one-hot. out_valid=1 iff out!=0. When out_valid=1, out==1<<idx.
- err and wrap are low in every cycle not explicitly specified above.

Test Plan:
- Reset, then en=1, mode=0, sel_valid=1 with sel=0..7 on consecutive cycles -> each following cycle shows out=8'h01,8'h02,...,8'h80, idx=sel, out_valid=1.
- N_OUT=6: sel=5 -> out=6'b100000. Then sel=6 -> out=0, out_valid=0, err high for 1 cycle only. Then sel=2 -> out=6'b000100.
- mode=1, dwell=2, N_OUT=8 -> each bit is held 3 cycles, sequence 01,02,04..80. wrap=1 exactly in the cycle out returns to 8'h01 (cycle 24 after entry).
- mode=1, dwell=0 -> out advances every cycle. wrap pulses every 8 cycles. out is never zero or multi-hot.
- Mid-scan at idx=4: assert rst -> next cycle all outputs are 0. Separately, at idx=4 drop en -> out=0 and the state is IDLE. Re-enable in scan mode -> the scan restarts at out=8'h01.
- Mid-scan switch to mode=0 with sel_valid=1, sel=3 in the same cycle -> out=0, out_valid=0, no err. A later sel_valid with sel=3 -> out=8'h08.

Source files
------------

// File: rtl/onehot_decoder_scan.sv
// Registered N-to-one-hot decoder with a direct decode mode and an
// autonomous scan mode that walks the one-hot output across all channels
// with a programmable dwell. Every output is a flop; no input reaches an
// output without passing through a clock edge.
module onehot_decoder_scan #(
    parameter int SEL_W   = 3,
    parameter int N_OUT   = 8,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               sel_valid,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [N_OUT-1:0]   out,
    output logic [SEL_W-1:0]   idx,
    output logic               out_valid,
    output logic               err,
    output logic               wrap
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // One extra bit so N_OUT == 2**SEL_W is representable for the range check.
    localparam logic [SEL_W:0]   N_OUT_X  = (SEL_W + 1)'(N_OUT);
    // Scan wraps at N_OUT, not at 2**SEL_W.
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_OUT - 1);
    localparam logic [N_OUT-1:0] BIT0     = {{(N_OUT - 1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [DWELL_W-1:0] cnt_r;

    // Mode FSM, dwell counter and all registered outputs. Priority is
    // rst, then en=0, then a mode change, then sel_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {DWELL_W{1'b0}};
            out       <= {N_OUT{1'b0}};
            idx       <= {SEL_W{1'b0}};
            out_valid <= 1'b0;
            err       <= 1'b0;
            wrap      <= 1'b0;
        end else if (!en) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {DWELL_W{1'b0}};
            out       <= {N_OUT{1'b0}};
            idx       <= {SEL_W{1'b0}};
            out_valid <= 1'b0;
            err       <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            // Pulses default low; only the cases below raise them.
            err  <= 1'b0;
            wrap <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DIRECT: begin
                    if (mode) begin
                        // Scan always restarts from channel 0.
                        state_r   <= ST_SCAN;
                        cnt_r     <= {DWELL_W{1'b0}};
                        out       <= BIT0;
                        idx       <= {SEL_W{1'b0}};
                        out_valid <= 1'b1;
                    end else if (state_r == ST_IDLE) begin
                        // Direct starts dark until the first accepted sel.
                        state_r   <= ST_DIRECT;
                        cnt_r     <= {DWELL_W{1'b0}};
                        out       <= {N_OUT{1'b0}};
                        idx       <= {SEL_W{1'b0}};
                        out_valid <= 1'b0;
                    end else if (sel_valid) begin
                        if ({1'b0, sel} < N_OUT_X) begin
                            out       <= BIT0 << sel;
                            idx       <= sel;
                            out_valid <= 1'b1;
                        end else begin
                            // Out-of-range select: go dark, keep idx, flag once.
                            out       <= {N_OUT{1'b0}};
                            out_valid <= 1'b0;
                            err       <= 1'b1;
                        end
                    end else begin
                        out       <= out;
                        idx       <= idx;
                        out_valid <= out_valid;
                    end
                end
                ST_SCAN: begin
                    if (!mode) begin
                        // Leaving scan discards any sel presented this cycle.
                        state_r   <= ST_DIRECT;
                        cnt_r     <= {DWELL_W{1'b0}};
                        out       <= {N_OUT{1'b0}};
                        idx       <= {SEL_W{1'b0}};
                        out_valid <= 1'b0;
                    end else if (cnt_r == dwell) begin
                        cnt_r <= {DWELL_W{1'b0}};
                        if (idx == LAST_IDX) begin
                            out  <= BIT0;
                            idx  <= {SEL_W{1'b0}};
                            wrap <= 1'b1;
                        end else begin
                            out <= out << 1;
                            idx <= idx + {{(SEL_W - 1){1'b0}}, 1'b1};
                        end
                    end else begin
                        // A dwell lowered below the count runs through the
                        // natural rollover before matching again.
                        cnt_r <= cnt_r + {{(DWELL_W - 1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= {DWELL_W{1'b0}};
                    out       <= {N_OUT{1'b0}};
                    idx       <= {SEL_W{1'b0}};
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
